orbit_camera_basis: RTL

- Parametrised, handshaked successor to the fixed-width camera block: turns spherical orbit angles (sin/cos of phi, theta) and a radius into camera position plus an orthonormal basis (n, u, v) for the projection stage.
- Fully pipelined with valid/ready flow control and rounding and saturation.
- Flags degenerate near-pole orientations.
- Sits between the trig/angle front end and the vertex projection pipeline.

---
 rtl/orbit_camera_pkg.sv | 57 +++++
 rtl/orbit_camera_basis_fx_mul_rs.sv | 56 +++++
 rtl/orbit_camera_basis.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/orbit_camera_pkg.sv
// ============================================================================
//  Module   : orbit_camera_pkg
//  Purpose  : Shared widths, packed vec3 types and fixed-point round/saturate
//             helpers for the orbit camera basis pipeline.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef OCB_TRIG_W
`define OCB_TRIG_W 16
`endif
`ifndef OCB_RAD_W
`define OCB_RAD_W 18
`endif

package orbit_camera_pkg;

   localparam int TRIG_W_DEF    = `OCB_TRIG_W;
   localparam int TRIG_FRAC_DEF = 14;
   localparam int RAD_W_DEF     = `OCB_RAD_W;
   localparam int RAD_FRAC_DEF  = 8;
   localparam int POLE_EPS_DEF  = 16;

   // Packed 3-vectors, element [0] is x.
   typedef logic signed [2:0][`OCB_TRIG_W-1:0] trig_vec3_t;
   typedef logic signed [2:0][`OCB_RAD_W-1:0]  rad_vec3_t;

   // Round-half-up, arithmetic shift by frac, saturate to out_w bits.
   // Result is {overflow, 64-bit sign-extended value}.
   function automatic logic [64:0] sat_round_shift(input logic signed [63:0] prod,
                                                   input int frac,
                                                   input int out_w);
      logic signed [63:0] shf;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      shf   = (prod + (64'sd1 <<< (frac - 1))) >>> frac;
      max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (out_w - 1));
      if (shf > max_v)      sat_round_shift = {1'b1, max_v};
      else if (shf < min_v) sat_round_shift = {1'b1, min_v};
      else                  sat_round_shift = {1'b0, shf};
   endfunction

   // Two's complement negate; the most negative w-bit value maps to +max.
   function automatic logic [64:0] sat_neg(input logic signed [63:0] a,
                                           input int w);
      logic signed [63:0] neg;
      logic signed [63:0] max_v;
      neg   = -a;
      max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
      if (neg > max_v) sat_neg = {1'b1, max_v};
      else             sat_neg = {1'b0, neg};
   endfunction

endpackage

`default_nettype wire

// File: rtl/orbit_camera_basis_fx_mul_rs.sv
// ============================================================================
//  Module   : fx_mul_rs
//  Purpose  : Signed multiplier followed by one register stage holding the
//             rounded, shifted and saturated product plus its overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fx_mul_rs
   import orbit_camera_pkg::*;
#(
   parameter int A_W   = 18,
   parameter int B_W   = 16,
   parameter int FRAC  = 14,
   parameter int OUT_W = 18
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic signed [A_W-1:0]   a_i,
   input  logic signed [B_W-1:0]   b_i,
   output logic signed [OUT_W-1:0] p_o,
   output logic                    ovf_o
);

   logic signed [A_W+B_W-1:0] prod;
   logic [64:0]               rs;
   logic signed [OUT_W-1:0]   p_d;
   logic                      ovf_d;
   logic signed [OUT_W-1:0]   p_q;
   logic                      ovf_q;
   logic                      unused_rs_hi;

   assign prod         = (A_W+B_W)'(a_i) * (A_W+B_W)'(b_i);
   assign rs           = sat_round_shift(64'(prod), FRAC, OUT_W);
   assign p_d          = rs[OUT_W-1:0];
   assign ovf_d        = rs[64];
   assign unused_rs_hi = ^rs[63:OUT_W];

   // Capture the conditioned product whenever the pipeline advances.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         p_q   <= '0;
         ovf_q <= 1'b0;
      end else if (en_i) begin
         p_q   <= p_d;
         ovf_q <= ovf_d;
      end
   end

   assign p_o   = p_q;
   assign ovf_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/orbit_camera_basis.sv
// ============================================================================
//  Module   : orbit_camera_basis
//  Purpose  : Orbit angles + radius -> camera position and orthonormal basis
//             (n, u, v), valid/ready pipelined, with pole and saturation flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module orbit_camera_basis
   import orbit_camera_pkg::*;
#(
   parameter int TRIG_W    = TRIG_W_DEF,
   parameter int TRIG_FRAC = TRIG_FRAC_DEF,
   parameter int RAD_W     = RAD_W_DEF,
   parameter int RAD_FRAC  = RAD_FRAC_DEF,
   parameter int POLE_EPS  = POLE_EPS_DEF
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic signed [TRIG_W-1:0] sin_phi_in,
   input  logic signed [TRIG_W-1:0] cos_phi_in,
   input  logic signed [TRIG_W-1:0] sin_theta_in,
   input  logic signed [TRIG_W-1:0] cos_theta_in,
   input  logic signed [RAD_W-1:0]  radius_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   output logic [3*RAD_W-1:0]      pos_out,
   output logic [3*TRIG_W-1:0]     n_out,
   output logic [3*TRIG_W-1:0]     u_out,
   output logic [3*TRIG_W-1:0]     v_out,
   output logic                    pole_out,
   output logic                    sat_out,
   output logic                    valid_out,
   input  logic                    ready_in
);

   // Position keeps the radius scaling since the trig factor is shifted out.
   logic [31:0] unused_rad_frac;
   assign unused_rad_frac = 32'(RAD_FRAC);

   logic en;
   logic accept;

   // S0 input registers
   logic                     vld0_q;
   logic signed [TRIG_W-1:0] sp0_q, cp0_q, st0_q, ct0_q;
   logic signed [RAD_W-1:0]  rad0_q;
   // S1 cross products and delayed operands
   logic signed [TRIG_W-1:0] xp [4];
   logic [3:0]               xovf;
   logic                     vld1_q;
   logic signed [TRIG_W-1:0] sp1_q, cp1_q, st1_q, ct1_q;
   logic signed [RAD_W-1:0]  rad1_q;
   // S2 basis
   logic [64:0]              neg_st, neg_cpct, neg_cpst;
   logic                     unused_neg_hi;
   logic signed [TRIG_W:0]   sp_ext;
   logic [TRIG_W:0]          sp_mag;
   logic                     pole_d, sat2_d;
   logic                     vld2_q, pole2_q, sat2_q;
   logic [3*TRIG_W-1:0]      n2_q, u2_q, v2_q;
   logic signed [RAD_W-1:0]  rad2_q;
   // S3 output registers
   logic [3*RAD_W-1:0]       pos_w;
   logic [2:0]               pos_ovf;
   logic                     vld3_q, pole3_q, sat3_q;
   logic [3*TRIG_W-1:0]      n3_q, u3_q, v3_q;

   assign en        = !vld3_q || ready_in;
   assign ready_out = en && !rst_in;
   assign accept    = valid_in && ready_out;

   // S0: capture accepted operands; bubbles advance with stale data.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vld0_q <= 1'b0;
         sp0_q  <= '0;
         cp0_q  <= '0;
         st0_q  <= '0;
         ct0_q  <= '0;
         rad0_q <= '0;
      end else if (en) begin
         vld0_q <= accept;
         if (accept) begin
            sp0_q  <= sin_phi_in;
            cp0_q  <= cos_phi_in;
            st0_q  <= sin_theta_in;
            ct0_q  <= cos_theta_in;
            rad0_q <= radius_in;
         end
      end
   end

   // S1 products in order: sp*ct, sp*st, cp*ct, cp*st.
   for (genvar i = 0; i < 4; i++) begin : g_xprod
      fx_mul_rs #(
         .A_W  (TRIG_W),
         .B_W  (TRIG_W),
         .FRAC (TRIG_FRAC),
         .OUT_W(TRIG_W)
      ) u_mul (
         .clk_i(clk_in),
         .rst_i(rst_in),
         .en_i (en),
         .a_i  ((i < 2) ? sp0_q : cp0_q),
         .b_i  ((i % 2 == 0) ? ct0_q : st0_q),
         .p_o  (xp[i]),
         .ovf_o(xovf[i])
      );
   end

   // S1: carry raw trig and radius alongside the products.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vld1_q <= 1'b0;
         sp1_q  <= '0;
         cp1_q  <= '0;
         st1_q  <= '0;
         ct1_q  <= '0;
         rad1_q <= '0;
      end else if (en) begin
         vld1_q <= vld0_q;
         sp1_q  <= sp0_q;
         cp1_q  <= cp0_q;
         st1_q  <= st0_q;
         ct1_q  <= ct0_q;
         rad1_q <= rad0_q;
      end
   end

   assign neg_st        = sat_neg(64'(st1_q), TRIG_W);
   assign neg_cpct      = sat_neg(64'(xp[2]), TRIG_W);
   assign neg_cpst      = sat_neg(64'(xp[3]), TRIG_W);
   assign unused_neg_hi = ^{neg_st[63:TRIG_W], neg_cpct[63:TRIG_W], neg_cpst[63:TRIG_W]};

   // One extra bit so |most negative| is representable.
   assign sp_ext = {sp1_q[TRIG_W-1], sp1_q};
   assign sp_mag = sp_ext[TRIG_W] ? -sp_ext : sp_ext;
   assign pole_d = sp_mag < (TRIG_W+1)'(POLE_EPS);
   assign sat2_d = (|xovf) | neg_st[64] | neg_cpct[64] | neg_cpst[64];

   // S2: assemble n, u, v and the per-transaction flags.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vld2_q  <= 1'b0;
         n2_q    <= '0;
         u2_q    <= '0;
         v2_q    <= '0;
         rad2_q  <= '0;
         pole2_q <= 1'b0;
         sat2_q  <= 1'b0;
      end else if (en) begin
         vld2_q  <= vld1_q;
         n2_q    <= {cp1_q, xp[1], xp[0]};
         u2_q    <= {TRIG_W'(0), ct1_q, neg_st[TRIG_W-1:0]};
         v2_q    <= {sp1_q, neg_cpst[TRIG_W-1:0], neg_cpct[TRIG_W-1:0]};
         rad2_q  <= rad1_q;
         pole2_q <= pole_d;
         sat2_q  <= sat2_d;
      end
   end

   // S3 position: radius times each n component.
   for (genvar i = 0; i < 3; i++) begin : g_pos
      fx_mul_rs #(
         .A_W  (RAD_W),
         .B_W  (TRIG_W),
         .FRAC (TRIG_FRAC),
         .OUT_W(RAD_W)
      ) u_mul (
         .clk_i(clk_in),
         .rst_i(rst_in),
         .en_i (en),
         .a_i  (rad2_q),
         .b_i  ($signed(n2_q[i*TRIG_W +: TRIG_W])),
         .p_o  (pos_w[i*RAD_W +: RAD_W]),
         .ovf_o(pos_ovf[i])
      );
   end

   // S3: output register, aligned with the position multipliers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vld3_q  <= 1'b0;
         n3_q    <= '0;
         u3_q    <= '0;
         v3_q    <= '0;
         pole3_q <= 1'b0;
         sat3_q  <= 1'b0;
      end else if (en) begin
         vld3_q  <= vld2_q;
         n3_q    <= n2_q;
         u3_q    <= u2_q;
         v3_q    <= v2_q;
         pole3_q <= pole2_q;
         sat3_q  <= sat2_q;
      end
   end

   assign pos_out   = pos_w;
   assign n_out     = n3_q;
   assign u_out     = u3_q;
   assign v_out     = v3_q;
   assign pole_out  = pole3_q;
   assign sat_out   = sat3_q | (|pos_ovf);
   assign valid_out = vld3_q;

endmodule

`default_nettype wire
